// File: rtl/sdram_burst_write.sv
// -----------------------------------------------------------------------------
// sdram_burst_write
// Avalon-MM burst write master. Moves a burst of SDRAM_W-bit words from an
// on-chip producer to SDRAM starting at a given base address. A 2-entry FIFO
// decouples the producer valid/ready handshake from Avalon waitrequest.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   write_addr, write_cnt   burst base address / length (words), sampled on start
//   write_start             start pulse, honoured only when idle
//   busy, done              burst in progress / one-cycle completion pulse
//   in_valid, in_data       producer word and its valid
//   in_ready, in_idx        word accepted when valid && ready; index of next word
//   waitrequest             Avalon slave stall
//   write, address,         Avalon write master outputs
//   burstcount, writedata,
//   byteenable
// -----------------------------------------------------------------------------
module sdram_burst_write #(
    parameter int SDRAM_W = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          write_addr,
    input  logic [10:0]          write_cnt,
    input  logic                 write_start,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    input  logic [SDRAM_W-1:0]   in_data,
    output logic                 in_ready,
    output logic [10:0]          in_idx,
    input  logic                 waitrequest,
    output logic                 write,
    output logic [31:0]          address,
    output logic [10:0]          burstcount,
    output logic [SDRAM_W-1:0]   writedata,
    output logic [SDRAM_W/8-1:0] byteenable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]        addr_ff;
    logic [10:0]        cnt_ff;
    logic [10:0]        idx_ff;
    logic [10:0]        beat_ff;

    logic [SDRAM_W-1:0] fifo_mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_cnt;

    logic               push;
    logic               pop;
    logic               start_burst;
    logic               last_beat;

    // Datapath handshakes and Avalon outputs. Everything is gated by state so
    // an asynchronous reset drops write/busy/in_ready without waiting for a clock.
    always_comb begin
        in_ready    = (state == BURST) && (fifo_cnt < 2'd2) && (idx_ff < cnt_ff);
        write       = (state == BURST) && (fifo_cnt != 2'd0);
        push        = in_valid && in_ready;
        pop         = write && !waitrequest;
        last_beat   = pop && (beat_ff == (cnt_ff - 11'd1));
        start_burst = (state == IDLE) && write_start && (write_cnt != 11'd0);

        busy        = (state == BURST);
        done        = (state == DONE);
        in_idx      = idx_ff;
        address     = (state == BURST) ? addr_ff : '0;
        burstcount  = (state == BURST) ? cnt_ff  : '0;
        writedata   = write ? fifo_mem[rd_ptr] : '0;
        byteenable  = write ? '1 : '0;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (write_start) begin
                    // Zero-length request completes without any Avalon traffic.
                    state_nxt = (write_cnt != 11'd0) ? BURST : DONE;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst parameters and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_ff <= '0;
            cnt_ff  <= '0;
            idx_ff  <= '0;
            beat_ff <= '0;
        end else if (start_burst) begin
            addr_ff <= write_addr;
            cnt_ff  <= write_cnt;
            idx_ff  <= '0;
            beat_ff <= '0;
        end else begin
            if (push) begin
                idx_ff <= idx_ff + 11'd1;
            end
            if (pop) begin
                beat_ff <= beat_ff + 11'd1;
            end
        end
    end

    // 2-entry FIFO; simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else if (start_burst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= in_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
